enc_prio_pend: RTL and testbench

- Registered priority encoder with enable. It is the inverse of the team's enabled line decoder: it turns request lines into a binary index plus a valid flag.
- Arriving requests are latched into a pending register. The highest-index pending request is presented until it is acknowledged, then cleared.
- Sits between one-hot/request sources (buttons, decoder outputs, interrupt lines) and a consumer that needs one index at a time.

---
 rtl/dec_enc_pkg.sv | 25 ++
 rtl/prio_enc_comb.sv | 28 ++
 rtl/enc_prio_pend.sv | 109 ++++++++++
 tb/tb_enc_prio_pend.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dec_enc_pkg.sv
// -----------------------------------------------------------------------------
// dec_enc_pkg
// Shared definitions for the decoder/encoder block family.
//   - state_e    : two-state handshake FSM encoding (IDLE, HOLD)
//   - N_DEFAULT  : default number of request/decode lines
//   - one_hot()  : index -> one-hot vector, up to ONE_HOT_MAX lines
// -----------------------------------------------------------------------------
package dec_enc_pkg;

   localparam int N_DEFAULT     = 4;

   // Widest vector one_hot() can produce; callers size-cast the result down.
   localparam int ONE_HOT_MAX   = 32;
   localparam int ONE_HOT_IDX_W = $clog2(ONE_HOT_MAX);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   function automatic logic [ONE_HOT_MAX-1:0] one_hot(input logic [ONE_HOT_IDX_W-1:0] idx);
      one_hot = {{(ONE_HOT_MAX-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// -----------------------------------------------------------------------------
// prio_enc_comb
// Unregistered priority encoder: highest set index of pend wins.
// Ports:
//   pend [N-1:0]  input   request vector
//   idx  [W-1:0]  output  highest set index (0 when pend is all zero)
//   any           output  at least one bit of pend is set
// -----------------------------------------------------------------------------
module prio_enc_comb #(
   parameter int N = 4
) (
   input  logic [N-1:0]         pend,
   output logic [$clog2(N)-1:0] idx,
   output logic                 any
);

   localparam int W = $clog2(N);

   // Ascending scan: the last set bit seen is the highest index.
   always_comb begin
      idx = {W{1'b0}};
      any = |pend;
      for (int i = 0; i < N; i++) begin
         idx = pend[i] ? W'(i) : idx;
      end
   end

endmodule

// File: rtl/enc_prio_pend.sv
// -----------------------------------------------------------------------------
// enc_prio_pend
// Registered priority encoder with pending-request latch and ack handshake.
// Requests are accumulated in a pending register; the highest pending index is
// presented on A with V=1 until ack, then that bit is cleared.
// Ports:
//   clk          input   rising-edge clock
//   rst_n        input   synchronous active-low reset
//   E            input   capture enable for D
//   D   [N-1:0]  input   request lines, sampled every clock
//   ack          input   consumer accepts A (only meaningful while V=1)
//   A   [W-1:0]  output  presented index (holds last value while V=0)
//   V            output  A valid
//   OVF          output  sticky: request arrived on an already-pending line
// N is limited to dec_enc_pkg::ONE_HOT_MAX lines.
// -----------------------------------------------------------------------------
module enc_prio_pend
   import dec_enc_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 E,
   input  logic [N-1:0]         D,
   input  logic                 ack,
   output logic [$clog2(N)-1:0] A,
   output logic                 V,
   output logic                 OVF
);

   localparam int W = $clog2(N);

   state_e         state_q, state_d;
   logic [N-1:0]   pend_q,  pend_d;
   logic [W-1:0]   a_q,     a_d;
   logic           v_q,     v_d;
   logic           ovf_q,   ovf_d;

   logic [N-1:0]   clr_s;
   logic [W-1:0]   idx_s;
   logic           any_s;

   prio_enc_comb #(.N(N)) u_prio_enc (
      .pend (pend_q),
      .idx  (idx_s),
      .any  (any_s)
   );

   // Next-state: FSM, grant index, clear mask, pending capture and overflow.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      v_d     = v_q;
      clr_s   = {N{1'b0}};
      case (state_q)
         IDLE: begin
            if (any_s) begin
               state_d = HOLD;
               a_d     = idx_s;
               v_d     = 1'b1;
            end else begin
               state_d = IDLE;
               v_d     = 1'b0;
            end
         end
         HOLD: begin
            if (ack) begin
               state_d = IDLE;
               v_d     = 1'b0;
               clr_s   = N'(one_hot(ONE_HOT_IDX_W'(a_q)));
            end else begin
               state_d = HOLD;
               v_d     = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            v_d     = 1'b0;
         end
      endcase
      // Set is ORed in after the clear, so a same-cycle re-request survives ack.
      pend_d = (pend_q & ~clr_s) | (E ? D : {N{1'b0}});
      // A cleared bit being re-requested is a fresh request, not an overflow.
      ovf_d  = ovf_q | (E & (|(D & pend_q & ~clr_s)));
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= {N{1'b0}};
         a_q     <= {W{1'b0}};
         v_q     <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         a_q     <= a_d;
         v_q     <= v_d;
         ovf_q   <= ovf_d;
      end
   end

   assign A   = a_q;
   assign V   = v_q;
   assign OVF = ovf_q;

endmodule

// File: tb/tb_enc_prio_pend.sv
// -----------------------------------------------------------------------------
// tb_enc_prio_pend
// Directed scenarios followed by random traffic, each cycle compared against a
// behavioural model of pending set / current grant / overflow flag.
// -----------------------------------------------------------------------------
module tb_enc_prio_pend;

   localparam int N = 4;
   localparam int W = 2;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         E     = 1'b0;
   logic [N-1:0] D     = 4'b0000;
   logic         ack   = 1'b0;
   logic [W-1:0] A;
   logic         V;
   logic         OVF;

   int checks = 0;
   int errors = 0;

   // Behavioural model: set of pending lines, whether a grant is out, which one.
   bit m_pend[N];
   bit m_busy = 1'b0;
   int m_cur  = 0;
   bit m_ovf  = 1'b0;

   int grants[$];
   int vrun;

   enc_prio_pend #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .E     (E),
      .D     (D),
      .ack   (ack),
      .A     (A),
      .V     (V),
      .OVF   (OVF)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int top;
      int clr;
      bit nx[N];
      if (!rst_n) begin
         for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
         m_busy = 1'b0;
         m_cur  = 0;
         m_ovf  = 1'b0;
         return;
      end
      top = -1;
      for (int i = 0; i < N; i++) if (m_pend[i]) top = i;
      clr = (m_busy && ack) ? m_cur : -1;
      for (int i = 0; i < N; i++) begin
         nx[i] = (m_pend[i] && i != clr) || (E && D[i]);
         if (E && D[i] && m_pend[i] && i != clr) m_ovf = 1'b1;
      end
      if (!m_busy) begin
         if (top >= 0) begin
            m_busy = 1'b1;
            m_cur  = top;
         end
      end else if (ack) begin
         m_busy = 1'b0;
      end
      for (int i = 0; i < N; i++) m_pend[i] = nx[i];
   endtask

   function automatic logic [N-1:0] model_pend_vec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = m_pend[i];
      return v;
   endfunction

   // One clock: advance the model with the inputs seen at the edge, then compare.
   task automatic cycle(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      chk({tag, ":V"},    {31'd0, V},   {31'd0, m_busy});
      chk({tag, ":A"},    {30'd0, A},   m_cur);
      chk({tag, ":OVF"},  {31'd0, OVF}, {31'd0, m_ovf});
      chk({tag, ":pend"}, {28'd0, dut.pend_q}, {28'd0, model_pend_vec()});
   endtask

   initial begin
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;

      // 1. reset then idle
      rst_n = 1'b0; D = 4'b0000; E = 1'b0; ack = 1'b0;
      cycle("rst"); cycle("rst");
      chk("rst_V", {31'd0, V}, 32'd0);
      chk("rst_A", {30'd0, A}, 32'd0);
      chk("rst_OVF", {31'd0, OVF}, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle("idle");
         chk("idle_V", {31'd0, V}, 32'd0);
      end

      // 2. single request, hold, ack
      E = 1'b1; D = 4'b0100;
      cycle("t2cap");
      chk("t2cap_V", {31'd0, V}, 32'd0);
      D = 4'b0000;
      cycle("t2gnt");
      chk("t2gnt_V", {31'd0, V}, 32'd1);
      chk("t2gnt_A", {30'd0, A}, 32'd2);
      for (int i = 0; i < 5; i++) begin
         cycle("t2hold");
         chk("t2hold_A", {30'd0, A}, 32'd2);
         chk("t2hold_V", {31'd0, V}, 32'd1);
      end
      ack = 1'b1;
      cycle("t2ack");
      chk("t2ack_V", {31'd0, V}, 32'd0);
      chk("t2ack_pend", {28'd0, dut.pend_q}, 32'd0);
      ack = 1'b0;
      cycle("t2end");

      // 3. priority and drain with ack held high
      D = 4'b1011;
      cycle("t3cap");
      D = 4'b0000; ack = 1'b1;
      grants.delete();
      vrun = 0;
      for (int i = 0; i < 8; i++) begin
         cycle("t3drain");
         if (V) begin
            grants.push_back(int'(A));
            vrun++;
         end else begin
            vrun = 0;
         end
         chk("t3_pulse_len", (vrun > 1) ? 32'd1 : 32'd0, 32'd0);
      end
      chk("t3_ngrants", grants.size(), 32'd3);
      if (grants.size() == 3) begin
         chk("t3_g0", grants[0], 32'd3);
         chk("t3_g1", grants[1], 32'd1);
         chk("t3_g2", grants[2], 32'd0);
      end
      chk("t3_final_V", {31'd0, V}, 32'd0);
      ack = 1'b0;

      // 4. enable gating
      E = 1'b0; D = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         cycle("t4off");
         chk("t4off_V", {31'd0, V}, 32'd0);
      end
      E = 1'b1; D = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         cycle("t4on");
         chk("t4on_V", {31'd0, V}, 32'd0);
      end

      // 5. set-vs-clear collision, then overflow
      D = 4'b0010;
      cycle("t5cap");
      D = 4'b0000;
      cycle("t5gnt");
      chk("t5gnt_A", {30'd0, A}, 32'd1);
      ack = 1'b1; D = 4'b0010;
      cycle("t5coll");
      chk("t5coll_pend", {28'd0, dut.pend_q}, 32'h2);
      chk("t5coll_OVF", {31'd0, OVF}, 32'd0);
      ack = 1'b0; D = 4'b0000;
      cycle("t5regnt");
      chk("t5regnt_V", {31'd0, V}, 32'd1);
      chk("t5regnt_A", {30'd0, A}, 32'd1);
      D = 4'b0010;
      cycle("t5ovf");
      chk("t5ovf_OVF", {31'd0, OVF}, 32'd1);
      D = 4'b0000; ack = 1'b1;
      cycle("t5drain");
      ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle("t5sticky");
         chk("t5sticky_OVF", {31'd0, OVF}, 32'd1);
      end

      // 6. reset mid-HOLD
      D = 4'b1100;
      cycle("t6cap");
      D = 4'b0000;
      cycle("t6gnt");
      chk("t6gnt_A", {30'd0, A}, 32'd3);
      chk("t6gnt_pend", {28'd0, dut.pend_q}, 32'hC);
      rst_n = 1'b0;
      cycle("t6rst");
      chk("t6rst_V", {31'd0, V}, 32'd0);
      chk("t6rst_A", {30'd0, A}, 32'd0);
      chk("t6rst_OVF", {31'd0, OVF}, 32'd0);
      chk("t6rst_pend", {28'd0, dut.pend_q}, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle("t6after");
         chk("t6after_V", {31'd0, V}, 32'd0);
      end

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         E     = ($urandom_range(0, 3) != 0);
         D     = ($urandom_range(0, 2) == 0) ? N'($urandom) : 4'b0000;
         ack   = $urandom_range(0, 1) == 1;
         rst_n = ($urandom_range(0, 60) != 0);
         cycle("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
